// File: rtl/usrt_cfg_seq_if.sv
// Register bus between the configuration sequencer (master) and statusreg (slave).
interface usrt_cfg_seq_if;
    logic       enable;
    logic       pwrite;
    logic [7:0] data;
    logic       ready;
    logic [7:0] status;

    modport master (output enable, output pwrite, output data, input ready, input status);
    modport slave  (input enable, input pwrite, input data, output ready, output status);
endinterface

// File: rtl/usrt_cfg_seq.sv
// Writes a configuration byte to statusreg, reads it back, compares under a mask
// and retries on mismatch or ready timeout.
module usrt_cfg_seq #(
    parameter int         TIMEOUT_CYCLES = 16,
    parameter int         MAX_RETRY      = 2,
    parameter logic [7:0] CHECK_MASK     = 8'hFF
) (
    input  logic          i_Pclk,
    input  logic          i_Reset,
    input  logic          i_Req,
    input  logic [7:0]    i_Cfg,
    output logic          o_Busy,
    output logic          o_Done,
    output logic          o_Error,
    output logic [1:0]    o_RetryCnt,
    output logic [7:0]    o_Cfg,
    usrt_cfg_seq_if.master bus
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_WR_WAIT = 3'd2;
    localparam logic [2:0] ST_RD      = 3'd3;
    localparam logic [2:0] ST_RD_WAIT = 3'd4;
    localparam logic [2:0] ST_CHECK   = 3'd5;

    localparam int              WW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      RETRY_MAX = 2'(MAX_RETRY);

    logic [2:0]    state_r, state_nxt_s;
    logic [WW-1:0] wait_r, wait_nxt_s;
    logic [1:0]    retry_r, retry_nxt_s;
    logic [7:0]    cfg_r, cfg_nxt_s;
    logic [7:0]    rb_r, rb_nxt_s;
    logic [7:0]    ocfg_r, ocfg_nxt_s;
    logic          done_r, done_nxt_s;
    logic          error_r, error_nxt_s;
    logic          busy_r, busy_nxt_s;
    logic          enable_r, enable_nxt_s;
    logic          pwrite_r, pwrite_nxt_s;
    logic [7:0]    data_r, data_nxt_s;
    logic          fail_s;

    function automatic logic masked_eq(input logic [7:0] a, input logic [7:0] b);
        return ((a & CHECK_MASK) == (b & CHECK_MASK));
    endfunction

    // Detect the conditions that send an attempt down the retry/error path.
    always_comb begin
        fail_s = 1'b0;
        case (state_r)
            ST_WR_WAIT, ST_RD_WAIT: fail_s = !bus.ready && (wait_r == WAIT_LAST);
            ST_CHECK:               fail_s = !masked_eq(rb_r, cfg_r);
            default:                fail_s = 1'b0;
        endcase
    end

    // Next-state and datapath logic.
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_r;
        retry_nxt_s = retry_r;
        cfg_nxt_s   = cfg_r;
        rb_nxt_s    = rb_r;
        ocfg_nxt_s  = ocfg_r;
        done_nxt_s  = 1'b0;
        error_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_Req) begin
                    cfg_nxt_s   = i_Cfg;
                    retry_nxt_s = 2'd0;
                    state_nxt_s = ST_WR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR: begin
                wait_nxt_s  = '0;
                state_nxt_s = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (bus.ready) begin
                    state_nxt_s = ST_RD;
                end else begin
                    wait_nxt_s = wait_r + WW'(1);
                end
            end
            ST_RD: begin
                wait_nxt_s  = '0;
                state_nxt_s = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (bus.ready) begin
                    rb_nxt_s    = bus.status;
                    state_nxt_s = ST_CHECK;
                end else begin
                    wait_nxt_s = wait_r + WW'(1);
                end
            end
            ST_CHECK: begin
                if (masked_eq(rb_r, cfg_r)) begin
                    ocfg_nxt_s  = cfg_r;
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        // A failed attempt overrides whatever the state case chose.
        if (fail_s) begin
            if (retry_r < RETRY_MAX) begin
                retry_nxt_s = retry_r + 2'd1;
                state_nxt_s = ST_WR;
            end else begin
                error_nxt_s = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        end else begin
            error_nxt_s = 1'b0;
        end
    end

    // Bus and busy outputs are decoded from the next state so they register cleanly.
    always_comb begin
        busy_nxt_s   = (state_nxt_s != ST_IDLE);
        enable_nxt_s = 1'b0;
        pwrite_nxt_s = pwrite_r;
        data_nxt_s   = 8'h00;
        case (state_nxt_s)
            ST_WR: begin
                enable_nxt_s = 1'b1;
                pwrite_nxt_s = 1'b1;
                data_nxt_s   = cfg_nxt_s;
            end
            ST_RD: begin
                enable_nxt_s = 1'b1;
                pwrite_nxt_s = 1'b0;
            end
            default: enable_nxt_s = 1'b0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_Pclk or posedge i_Reset) begin
        if (i_Reset) begin
            state_r  <= ST_IDLE;
            wait_r   <= '0;
            retry_r  <= 2'd0;
            cfg_r    <= 8'h00;
            rb_r     <= 8'h00;
            ocfg_r   <= 8'h00;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
            busy_r   <= 1'b0;
            enable_r <= 1'b0;
            pwrite_r <= 1'b0;
            data_r   <= 8'h00;
        end else begin
            state_r  <= state_nxt_s;
            wait_r   <= wait_nxt_s;
            retry_r  <= retry_nxt_s;
            cfg_r    <= cfg_nxt_s;
            rb_r     <= rb_nxt_s;
            ocfg_r   <= ocfg_nxt_s;
            done_r   <= done_nxt_s;
            error_r  <= error_nxt_s;
            busy_r   <= busy_nxt_s;
            enable_r <= enable_nxt_s;
            pwrite_r <= pwrite_nxt_s;
            data_r   <= data_nxt_s;
        end
    end

    assign o_Busy     = busy_r;
    assign o_Done     = done_r;
    assign o_Error    = error_r;
    assign o_RetryCnt = retry_r;
    assign o_Cfg      = ocfg_r;
    assign bus.enable = enable_r;
    assign bus.pwrite = pwrite_r;
    assign bus.data   = data_r;

endmodule

// File: doc/usrt_cfg_seq.md
# usrt_cfg_seq

Configuration sequencer for the USRT status register. It accepts a one-byte configuration request (baud select and parity bits) and writes it into the status register over the register bus (enable/pwrite/data, ready). It then reads the register back, compares the readback under a mask, and retries on mismatch or timeout. It sits between the host-side control logic and `statusreg`, and is the only master driving that register.

## Interface
- `TIMEOUT_CYCLES`, 16, maximum cycles a wait state waits for `i_Ready` (≥2)
- `MAX_RETRY`, 2, retries after the first attempt before giving up (0..3)
- `CHECK_MASK`, 8'hFF, bits of the readback compared against the requested byte

- `i_Pclk` in 1: bus clock; all logic on its rising edge (single clock)
- `i_Reset` in 1: asynchronous, active-high reset
- `i_Req` in 1: start request, sampled only in IDLE
- `i_Cfg` in 8: configuration byte, captured on the edge where `i_Req` is accepted
- `o_Busy` out 1: high while a sequence is in progress
- `o_Done` out 1: one-cycle pulse, readback matched
- `o_Error` out 1: one-cycle pulse, all attempts failed
- `o_RetryCnt` out 2: retries used in the current or last sequence
- `o_Cfg` out 8: last verified configuration
- `o_Enable` out 1: to `statusreg` `i_Enable`
- `o_Pwrite` out 1: to `statusreg` `i_Pwrite` (1 = write, 0 = read)
- `o_Data` out 8: to `statusreg` `i_Data`
- `i_Ready` in 1: from `statusreg` `o_Ready`
- `i_Status` in 8: from `statusreg` `o_Status`

## Operation
- States: IDLE, WR, WR_WAIT, RD, RD_WAIT, CHECK. All outputs are registered.
- IDLE: when `i_Req`=1, capture `i_Cfg` into `cfg_q`, clear `o_RetryCnt`, and go to WR.
- WR (1 cycle): `o_Enable`=1, `o_Pwrite`=1, `o_Data`=`cfg_q`; next state is WR_WAIT.
- WR_WAIT: `o_Enable`=0 and `o_Data`=0. If `i_Ready`=1, go to RD. Otherwise increment the wait counter; on reaching TIMEOUT_CYCLES, take the fail path.
- RD (1 cycle): `o_Enable`=1, `o_Pwrite`=0, `o_Data`=0; next state is RD_WAIT.
- RD_WAIT: same ready/timeout rule as WR_WAIT. When `i_Ready`=1, capture `i_Status` into `rb_q` and go to CHECK.
- CHECK (1 cycle): match = `(rb_q & CHECK_MASK) == (cfg_q & CHECK_MASK)`.
  - On a match: `o_Cfg`←`cfg_q`, `o_Done` pulse next cycle, return to IDLE.
  - On a mismatch: take the fail path.
- Fail path:
  - If `o_RetryCnt` < MAX_RETRY: increment `o_RetryCnt` and go to WR, rewriting the same `cfg_q`.
  - Otherwise: `o_Error` pulse next cycle, return to IDLE. `o_Cfg` is unchanged.
- The wait counter clears on every entry to WR_WAIT or RD_WAIT.
- `i_Ready` is ignored in every state except WR_WAIT and RD_WAIT, including the WR/RD enable cycle itself.
- `i_Req` while busy is ignored and not queued. `i_Cfg` changes after acceptance have no effect.
- `o_Pwrite` holds its last value when `o_Enable`=0 (don't-care to the slave).

## Timing
- Reset values: all outputs 0, `o_Cfg`=0, `o_RetryCnt`=0, state IDLE, counters 0.
- Asserting `i_Reset` mid-sequence returns to IDLE immediately and drops `o_Enable`/`o_Busy`. No `o_Done` or `o_Error` is issued for the aborted sequence.
- Best-case latency, with `i_Req` sampled at edge 0:
  - WR during cycle 1.
  - `i_Ready` high in cycle 2 (WR_WAIT).
  - RD in cycle 3.
  - `i_Ready` high in cycle 4 (RD_WAIT).
  - CHECK in cycle 5.
  - `o_Done`=1 in cycle 6.
- `o_Busy`=1 in cycles 1–5 and is 0 in the `o_Done`/`o_Error` cycle. A new `i_Req` in that cycle is accepted.
- Each wait state lasts at most TIMEOUT_CYCLES cycles. If `i_Ready`=1 on the final allowed cycle, ready wins over timeout.
- Each retry adds at least 5 cycles (WR through CHECK). Worst case is (MAX_RETRY+1) attempts, then the `o_Error` pulse.
- `o_Done` and `o_Error` are never high in the same cycle, and each pulse lasts exactly one cycle.

## Test plan
- Nominal: `statusreg` attached. `i_Req` with `i_Cfg`=8'h0D → WR cycle with `o_Data`=8'h0D, then an RD cycle. `o_Done` arrives 6 cycles after acceptance (with 1-cycle ready), `o_Cfg`=8'h0D, `o_RetryCnt`=0.
- Mismatch retry: model returns 8'h0C on the first read and 8'h0D afterwards → exactly one rewrite of 8'h0D, then `o_Done` with `o_RetryCnt`=1.
- Timeout exhaustion: `i_Ready` tied 0 → 3 WR cycles spaced 17 cycles apart (WR + 16 wait), then `o_Error` pulse with `o_RetryCnt`=2 and `o_Cfg` unchanged.
- Mask: CHECK_MASK=8'h0F, readback 8'hFD for request 8'h0D → `o_Done`, no retry.
- Busy/req: second `i_Req` with 8'h33 during RD_WAIT → ignored, only 8'h0D written. `i_Req` in the `o_Done` cycle → accepted, next WR 1 cycle later.
- Async reset asserted during WR_WAIT, between clock edges → `o_Busy`/`o_Enable`=0 immediately, no `o_Done`/`o_Error`. A later request completes normally.
